// File: rtl/phase_sequence_timer.sv
// phase_sequence_timer: N-phase countdown timer with hold, skip, stop and restart controls.
// Define PHASE_TIMER_PRESCALE_EN to slow the countdown to one decrement per PRESCALE cycles.
module phase_sequence_timer #(
  parameter int CNT_W      = 27,
  parameter int NUM_PHASES = 3,
  parameter int AUTO_WRAP  = 1,
  parameter int PRESCALE   = 50,
  localparam int PH_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        hold,
  input  logic                        skip,
  input  logic [NUM_PHASES*CNT_W-1:0] dur,
  output logic [PH_W-1:0]             phase,
  output logic [CNT_W-1:0]            remaining,
  output logic                        busy,
  output logic                        timeout,
  output logic                        seq_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d, phase_nxt;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              to_q, to_d, sd_q, sd_d;
  logic              last, tick, terminal;
  logic [CNT_W-1:0]  dur_a [NUM_PHASES];

  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_dur
    assign dur_a[g] = dur[g*CNT_W +: CNT_W];
  end

`ifdef PHASE_TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] pre_q;

  assign tick = (pre_q == PS_W'(PRESCALE - 1));

  // Any load or abort restarts the prescale window so each phase gets full ticks.
  always_ff @(posedge clk) begin
    if (rst)                                      pre_q <= '0;
    else if (state_q != RUN || start || stop || skip) pre_q <= '0;
    else if (!hold)                               pre_q <= tick ? '0 : pre_q + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  assign last      = (phase_q == PH_W'(NUM_PHASES - 1));
  assign phase_nxt = last ? '0 : phase_q + 1'b1;
  // skip overrides hold and the prescaler.
  assign terminal  = skip || (!hold && tick && (rem_q == '0));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    to_d    = 1'b0;
    sd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          phase_d = '0;
          rem_d   = dur_a[0];
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          phase_d = '0;
          rem_d   = '0;
        end else if (start) begin
          phase_d = '0;
          rem_d   = dur_a[0];
        end else if (terminal) begin
          to_d = 1'b1;
          if (last) begin
            sd_d    = 1'b1;
            phase_d = '0;
            if (AUTO_WRAP != 0) begin
              rem_d = dur_a[0];
            end else begin
              state_d = IDLE;
              rem_d   = '0;
            end
          end else begin
            phase_d = phase_nxt;
            rem_d   = dur_a[phase_nxt];
          end
        end else if (!hold && tick) begin
          rem_d = rem_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      rem_q   <= '0;
      to_q    <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      to_q    <= to_d;
      sd_q    <= sd_d;
    end
  end

  assign phase     = phase_q;
  assign remaining = rem_q;
  assign busy      = (state_q == RUN);
  assign timeout   = to_q;
  assign seq_done  = sd_q;

endmodule

// File: tb/tb_phase_sequence_timer.sv
// Scoreboarded directed bench: u_wrap (AUTO_WRAP=1) and u_once (AUTO_WRAP=0), CNT_W=8, 3 phases.
// dur = {3,1,5} packs phase0=5, phase1=1, phase2=3.
module tb_phase_sequence_timer;
  localparam int CW = 8;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       start_v, stop_v, hold_v, skip_v;
  logic [NP*CW-1:0] dur;
  logic [1:0]       phase_o [2];
  logic [CW-1:0]    rem_o [2];
  logic [1:0]       busy_o, to_o, sd_o;

  phase_sequence_timer #(.CNT_W(CW), .NUM_PHASES(NP), .AUTO_WRAP(1), .PRESCALE(4)) u_wrap (
    .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]), .hold(hold_v[0]),
    .skip(skip_v[0]), .dur(dur), .phase(phase_o[0]), .remaining(rem_o[0]),
    .busy(busy_o[0]), .timeout(to_o[0]), .seq_done(sd_o[0]));

  phase_sequence_timer #(.CNT_W(CW), .NUM_PHASES(NP), .AUTO_WRAP(0), .PRESCALE(4)) u_once (
    .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]), .hold(hold_v[1]),
    .skip(skip_v[1]), .dur(dur), .phase(phase_o[1]), .remaining(rem_o[1]),
    .busy(busy_o[1]), .timeout(to_o[1]), .seq_done(sd_o[1]));

  typedef struct {
    int         cyc;
    int         w;
    logic [1:0] ph;
    logic [7:0] rem;
    logic       busy, to, sd;
    string      tag;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] ph;
    logic       sd;
    string      tag;
  } ev_t;

  exp_t sbq[$];
  ev_t  evq0[$], evq1[$];
  int   cyc = 0;
  int   n_cmp = 0, n_fail = 0;
  logic done = 1'b0, fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot scoreboard: compare every expectation tagged for this cycle.
  exp_t me;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me = sbq.pop_front();
      n_cmp++;
      if (me.cyc != cyc || phase_o[me.w] !== me.ph || rem_o[me.w] !== me.rem ||
          busy_o[me.w] !== me.busy || to_o[me.w] !== me.to || sd_o[me.w] !== me.sd) begin
        n_fail++;
        $display("FAIL %s (inst %0d cyc %0d): got ph=%0d rem=%0d busy=%b to=%b sd=%b, want ph=%0d rem=%0d busy=%b to=%b sd=%b",
                 me.tag, me.w, cyc, phase_o[me.w], rem_o[me.w], busy_o[me.w], to_o[me.w], sd_o[me.w],
                 me.ph, me.rem, me.busy, me.to, me.sd);
      end
    end
    ev_check(0);
    ev_check(1);
    if (done && !fin) begin
      fin = 1'b1;
      n_cmp++;
      if (sbq.size() != 0 || evq0.size() != 0 || evq1.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_expectations: got %0d/%0d/%0d pending, want 0/0/0",
                 sbq.size(), evq0.size(), evq1.size());
      end
    end
  end

  // Pulse monitor: every timeout the DUT raises must match a queued event.
  task automatic ev_check(input int w);
    ev_t e;
    logic have;
    have = (w == 0) ? (evq0.size() > 0) : (evq1.size() > 0);
    if (to_o[w] === 1'b1) begin
      n_cmp++;
      if (!have) begin
        n_fail++;
        $display("FAIL unexpected_timeout (inst %0d cyc %0d): got timeout=1, want 0", w, cyc);
      end else begin
        e = (w == 0) ? evq0.pop_front() : evq1.pop_front();
        if (e.cyc != cyc || phase_o[w] !== e.ph || sd_o[w] !== e.sd) begin
          n_fail++;
          $display("FAIL ev_%s (inst %0d): got cyc=%0d ph=%0d sd=%b, want cyc=%0d ph=%0d sd=%b",
                   e.tag, w, cyc, phase_o[w], sd_o[w], e.cyc, e.ph, e.sd);
        end
      end
    end else if (have && ((w == 0) ? evq0[0].cyc : evq1[0].cyc) <= cyc) begin
      e = (w == 0) ? evq0.pop_front() : evq1.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missed_timeout_%s (inst %0d cyc %0d): got timeout=0, want 1", e.tag, w, cyc);
    end
  endtask

  task automatic step(input int w, input logic r, s, p, h, k,
                      input logic [1:0] eph, input logic [7:0] erem,
                      input logic eb, eto, esd, input string tag);
    exp_t e;
    ev_t  v;
    rst = r;
    start_v = '0; stop_v = '0; hold_v = '0; skip_v = '0;
    start_v[w] = s; stop_v[w] = p; hold_v[w] = h; skip_v[w] = k;
    e.cyc = cyc + 1; e.w = w; e.ph = eph; e.rem = erem;
    e.busy = eb; e.to = eto; e.sd = esd; e.tag = tag;
    sbq.push_back(e);
    if (eto) begin
      v.cyc = cyc + 1; v.ph = eph; v.sd = esd; v.tag = tag;
      if (w == 0) evq0.push_back(v); else evq1.push_back(v);
    end
    @(posedge clk); #1;
  endtask

  task automatic tk(input int w, input logic [1:0] eph, input logic [7:0] erem,
                    input logic eb, eto, esd, input string tag);
    step(w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eph, erem, eb, eto, esd, tag);
  endtask

  task automatic countdown(input int w, input logic [1:0] ph, input int from, input string tag);
    for (int r = from; r >= 0; r--) tk(w, ph, 8'(r), 1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_v = '0; stop_v = '0; hold_v = '0; skip_v = '0;
    dur = {8'd3, 8'd1, 8'd5};
    @(posedge clk); #1;
    step(0, 1'b1, 0, 0, 0, 0, 2'd0, 8'd0, 0, 0, 0, "reset_wrap");
    step(1, 1'b1, 0, 0, 0, 0, 2'd0, 8'd0, 0, 0, 0, "reset_once");
    tk(0, 2'd0, 8'd0, 0, 0, 0, "idle_after_reset");

`ifdef PHASE_TIMER_PRESCALE_EN
    // PRESCALE=4: every counter value lasts 4 cycles; dur1=0 gives a 4-cycle phase 1.
    dur = {8'd0, 8'd0, 8'd1};
    step(0, 0, 1, 0, 0, 0, 2'd0, 8'd1, 1, 0, 0, "ps_start");
    repeat (3) tk(0, 2'd0, 8'd1, 1, 0, 0, "ps_p0_r1");
    repeat (4) tk(0, 2'd0, 8'd0, 1, 0, 0, "ps_p0_r0");
    tk(0, 2'd1, 8'd0, 1, 1, 0, "ps_p1_enter");
    repeat (3) tk(0, 2'd1, 8'd0, 1, 0, 0, "ps_p1_hold");
    tk(0, 2'd2, 8'd0, 1, 1, 0, "ps_p2_enter");
    repeat (3) tk(0, 2'd2, 8'd0, 1, 0, 0, "ps_p2_hold");
    tk(0, 2'd0, 8'd1, 1, 1, 1, "ps_wrap");
    tk(0, 2'd0, 8'd1, 1, 0, 0, "ps_mid");
    step(0, 1'b1, 0, 0, 0, 0, 2'd0, 8'd0, 0, 0, 0, "ps_rst_mid");
    tk(0, 2'd0, 8'd0, 0, 0, 0, "ps_after_rst");
`else
    // Auto-wrap sequence: phase lengths 6, 2, 4 cycles.
    step(0, 0, 1, 0, 0, 0, 2'd0, 8'd5, 1, 0, 0, "t1_start");
    countdown(0, 2'd0, 4, "t1_p0");
    tk(0, 2'd1, 8'd1, 1, 1, 0, "t1_p1_enter");
    countdown(0, 2'd1, 0, "t1_p1");
    tk(0, 2'd2, 8'd3, 1, 1, 0, "t1_p2_enter");
    countdown(0, 2'd2, 2, "t1_p2");
    tk(0, 2'd0, 8'd5, 1, 1, 1, "t1_wrap");
    tk(0, 2'd0, 8'd4, 1, 0, 0, "t1_after_wrap");
    // Hold for 4 cycles at remaining=3.
    tk(0, 2'd0, 8'd3, 1, 0, 0, "t3_r3");
    repeat (4) step(0, 0, 0, 0, 1, 0, 2'd0, 8'd3, 1, 0, 0, "t3_hold");
    countdown(0, 2'd0, 2, "t3_resume");
    tk(0, 2'd1, 8'd1, 1, 1, 0, "t3_p1_enter");
    tk(0, 2'd1, 8'd0, 1, 0, 0, "t3_p1");
    tk(0, 2'd2, 8'd3, 1, 1, 0, "t3_p2_enter");
    tk(0, 2'd2, 8'd2, 1, 0, 0, "t5_p2_r2");
    // Restart mid-phase: no pulses.
    step(0, 0, 1, 0, 0, 0, 2'd0, 8'd5, 1, 0, 0, "t5_restart");
    tk(0, 2'd0, 8'd4, 1, 0, 0, "t4_r4");
    // Skip overrides hold.
    step(0, 0, 0, 0, 1, 1, 2'd1, 8'd1, 1, 1, 0, "t4_skip");
    step(0, 0, 0, 0, 1, 0, 2'd1, 8'd1, 1, 0, 0, "t4_hold_after_skip");
    step(0, 0, 0, 0, 0, 1, 2'd2, 8'd3, 1, 1, 0, "skip_p1");
    step(0, 0, 0, 0, 0, 1, 2'd0, 8'd5, 1, 1, 1, "skip_last");
    step(0, 0, 1, 1, 0, 0, 2'd0, 8'd0, 0, 0, 0, "t5_stop_wins");
    step(0, 0, 0, 0, 1, 1, 2'd0, 8'd0, 0, 0, 0, "idle_ignores_skip");
    step(0, 0, 0, 1, 0, 0, 2'd0, 8'd0, 0, 0, 0, "stop_in_idle");
    step(0, 0, 1, 0, 0, 0, 2'd0, 8'd5, 1, 0, 0, "rst_prep_start");
    tk(0, 2'd0, 8'd4, 1, 0, 0, "rst_prep_r4");
    step(0, 1'b1, 0, 0, 0, 1, 2'd0, 8'd0, 0, 0, 0, "rst_mid");
    tk(0, 2'd0, 8'd0, 0, 0, 0, "after_rst_mid");

    // One-shot: returns to IDLE after the last phase.
    step(1, 0, 1, 0, 0, 0, 2'd0, 8'd5, 1, 0, 0, "t2_start");
    countdown(1, 2'd0, 4, "t2_p0");
    tk(1, 2'd1, 8'd1, 1, 1, 0, "t2_p1_enter");
    countdown(1, 2'd1, 0, "t2_p1");
    tk(1, 2'd2, 8'd3, 1, 1, 0, "t2_p2_enter");
    countdown(1, 2'd2, 2, "t2_p2");
    tk(1, 2'd0, 8'd0, 0, 1, 1, "t2_end");
    tk(1, 2'd0, 8'd0, 0, 0, 0, "t2_idle");
    // Durations change mid-phase: current count unaffected, new dur1=0 used at next load.
    step(1, 0, 1, 0, 0, 0, 2'd0, 8'd5, 1, 0, 0, "dur_start");
    dur = {8'd3, 8'd0, 8'd2};
    countdown(1, 2'd0, 4, "dur_p0_unchanged");
    tk(1, 2'd1, 8'd0, 1, 1, 0, "dur_p1_zero");
    tk(1, 2'd2, 8'd3, 1, 1, 0, "dur_p2_enter");
    countdown(1, 2'd2, 2, "dur_p2");
    tk(1, 2'd0, 8'd0, 0, 1, 1, "dur_end");
`endif

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
